// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback for the TinyMIPS core: latches the MEM result,
// waits for synchronous RAM load data, aligns/extends it and drives the register-file write port.
module writeback_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_in,
    input  logic                      flush,
    input  logic                      mem_valid,
    input  logic                      mem_reg_wen,
    input  logic [REG_ADDR_WIDTH-1:0] mem_reg_waddr,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic                      mem_load,
    input  logic [2:0]                mem_load_type,
    input  logic [1:0]                mem_addr_lo,
    input  logic [DATA_WIDTH-1:0]     ram_rdata,
    input  logic                      ram_rvalid,
    output logic                      write_en,
    output logic [REG_ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic                      stall_req,
    output logic [CNT_WIDTH-1:0]      retired_cnt
);

    localparam logic [1:0] ST_EMPTY     = 2'd0;
    localparam logic [1:0] ST_RETIRE    = 2'd1;
    localparam logic [1:0] ST_LOAD_WAIT = 2'd2;

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;

    logic [1:0]                state_reg;
    logic                      reg_wen_reg;
    logic [REG_ADDR_WIDTH-1:0] waddr_reg;
    logic [DATA_WIDTH-1:0]     result_reg;
    logic                      load_reg;
    logic [2:0]                load_type_reg;
    logic [1:0]                addr_lo_reg;
    logic [DATA_WIDTH-1:0]     hold_data_reg;
    logic                      hold_valid_reg;
    logic                      retired_reg;
    logic [CNT_WIDTH-1:0]      cnt_reg;

    logic [7:0]            rdata_byte [4];
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] ext_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign rdata_byte[gi] = ram_rdata[gi*8 +: 8];
        end
    endgenerate

    // Halfword lane only looks at the upper offset bit; misaligned LH behaves as aligned.
    assign sel_byte = rdata_byte[addr_lo_reg];
    assign sel_half = addr_lo_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        ext_data = ram_rdata;
        case (load_type_reg)
            LT_LB:   ext_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
            LT_LBU:  ext_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
            LT_LH:   ext_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
            LT_LHU:  ext_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
            default: ext_data = ram_rdata;
        endcase
    end

    // Stall drops in the very cycle rvalid arrives so the upstream is not held an extra cycle.
    assign stall_req   = (state_reg == ST_LOAD_WAIT) && !ram_rvalid;
    assign write_en    = (state_reg == ST_RETIRE) && reg_wen_reg && (waddr_reg != '0);
    assign write_addr  = waddr_reg;
    assign write_data  = load_reg ? hold_data_reg : result_reg;
    assign retired_cnt = cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_EMPTY;
            reg_wen_reg    <= 1'b0;
            waddr_reg      <= '0;
            result_reg     <= '0;
            load_reg       <= 1'b0;
            load_type_reg  <= '0;
            addr_lo_reg    <= '0;
            hold_data_reg  <= '0;
            hold_valid_reg <= 1'b0;
            retired_reg    <= 1'b0;
            cnt_reg        <= '0;
        end else if (flush) begin
            state_reg      <= ST_EMPTY;
            hold_valid_reg <= 1'b0;
            retired_reg    <= 1'b0;
        end else begin
            // Count once per instruction; the flag keeps a held RETIRE from recounting.
            if (state_reg == ST_RETIRE && !retired_reg) begin
                cnt_reg     <= cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                retired_reg <= 1'b1;
            end
            if (state_reg == ST_LOAD_WAIT) begin
                if (ram_rvalid) begin
                    hold_data_reg  <= ext_data;
                    hold_valid_reg <= 1'b1;
                    state_reg      <= ST_RETIRE;
                end
            end else if (!stall_in) begin
                state_reg      <= !mem_valid ? ST_EMPTY : (mem_load ? ST_LOAD_WAIT : ST_RETIRE);
                reg_wen_reg    <= mem_reg_wen;
                waddr_reg      <= mem_reg_waddr;
                result_reg     <= mem_result;
                load_reg       <= mem_load;
                load_type_reg  <= mem_load_type;
                addr_lo_reg    <= mem_addr_lo;
                hold_valid_reg <= 1'b0;
                retired_reg    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU writeback, load alignment/extension,
// GPR0 gating, hold, flush and reset behaviour.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        flush;
    logic        mem_valid;
    logic        mem_reg_wen;
    logic [4:0]  mem_reg_waddr;
    logic [31:0] mem_result;
    logic        mem_load;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] ram_rdata;
    logic        ram_rvalid;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        stall_req;
    logic [31:0] retired_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [31:0] exp_cnt = 0;

    writeback_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_reg_wen   (mem_reg_wen),
        .mem_reg_waddr (mem_reg_waddr),
        .mem_result    (mem_result),
        .mem_load      (mem_load),
        .mem_load_type (mem_load_type),
        .mem_addr_lo   (mem_addr_lo),
        .ram_rdata     (ram_rdata),
        .ram_rvalid    (ram_rvalid),
        .write_en      (write_en),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .stall_req     (stall_req),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [4:0] waddr, input logic [31:0] res, input logic exp_wen);
        mem_valid = 1'b1; mem_reg_wen = 1'b1; mem_load = 1'b0;
        mem_reg_waddr = waddr; mem_result = res;
        tick();
        mem_valid = 1'b0;
        #1;
        check("alu_wen", {31'd0, write_en}, {31'd0, exp_wen});
        if (exp_wen) begin
            check("alu_addr", {27'd0, write_addr}, {27'd0, waddr});
            check("alu_data", write_data, res);
        end
        tick();
        exp_cnt++;
        check("alu_cnt", retired_cnt, exp_cnt);
        $display("alu   waddr=%0d data=%08h cnt=%0d", waddr, res, retired_cnt);
    endtask

    task automatic do_load(input logic [2:0] typ, input logic [1:0] lo, input logic [31:0] word,
                           input logic [31:0] exp, input int late);
        mem_valid = 1'b1; mem_reg_wen = 1'b1; mem_load = 1'b1;
        mem_load_type = typ; mem_addr_lo = lo; mem_reg_waddr = 5'd5; mem_result = 32'h5555_AAAA;
        tick();
        mem_valid = 1'b0; mem_load = 1'b0;
        for (int i = 0; i < late; i++) begin
            #1;
            check("ld_stall", {31'd0, stall_req}, 32'd1);
            check("ld_wen_wait", {31'd0, write_en}, 32'd0);
            tick();
        end
        ram_rvalid = 1'b1; ram_rdata = word;
        #1;
        check("ld_stall_drop", {31'd0, stall_req}, 32'd0);
        tick();
        ram_rvalid = 1'b0; ram_rdata = 32'h0;
        #1;
        check("ld_wen", {31'd0, write_en}, 32'd1);
        check("ld_data", write_data, exp);
        tick();
        exp_cnt++;
        check("ld_cnt", retired_cnt, exp_cnt);
        $display("load  type=%0d lo=%0d word=%08h exp=%08h", typ, lo, word, exp);
    endtask

    initial begin
        rst = 1'b0; stall_in = 1'b0; flush = 1'b0;
        mem_valid = 1'b1; mem_reg_wen = 1'b1; mem_reg_waddr = 5'd9; mem_result = 32'h1234_5678;
        mem_load = 1'b0; mem_load_type = 3'd0; mem_addr_lo = 2'd0;
        ram_rdata = 32'h0; ram_rvalid = 1'b0;

        tick();
        tick();
        check("rst_wen", {31'd0, write_en}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_cnt", retired_cnt, 32'd0);
        check("rst_data", write_data, 32'd0);
        $display("reset cnt=%0d", retired_cnt);
        mem_valid = 1'b0;
        rst = 1'b1;
        tick();

        alu_op(5'd3, 32'hDEAD_BEEF, 1'b1);

        do_load(3'd0, 2'd2, 32'h12C4_5678, 32'hFFFF_FFC4, 2);
        do_load(3'd1, 2'd2, 32'h12C4_5678, 32'h0000_00C4, 2);
        do_load(3'd2, 2'd2, 32'h12C4_5678, 32'h0000_12C4, 2);
        do_load(3'd2, 2'd0, 32'h1234_ABCD, 32'hFFFF_ABCD, 1);
        do_load(3'd3, 2'd1, 32'h1234_ABCD, 32'h0000_ABCD, 0);
        do_load(3'd0, 2'd3, 32'h8000_0000, 32'hFFFF_FF80, 1);
        do_load(3'd4, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
        do_load(3'd7, 2'd3, 32'h89AB_CDEF, 32'h89AB_CDEF, 1);

        alu_op(5'd0, 32'h0000_0042, 1'b0);

        // Held ALU op: write stays asserted, counted once.
        mem_valid = 1'b1; mem_reg_wen = 1'b1; mem_load = 1'b0;
        mem_reg_waddr = 5'd7; mem_result = 32'h0BAD_F00D;
        tick();
        mem_valid = 1'b0; stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_wen", {31'd0, write_en}, 32'd1);
            check("hold_data", write_data, 32'h0BAD_F00D);
            tick();
            check("hold_cnt", retired_cnt, exp_cnt + 32'd1);
        end
        stall_in = 1'b0;
        tick();
        exp_cnt++;
        check("hold_release_cnt", retired_cnt, exp_cnt);
        check("hold_release_wen", {31'd0, write_en}, 32'd0);
        $display("hold  cnt=%0d", retired_cnt);

        // Flush while waiting for load data; the late rvalid must be ignored.
        mem_valid = 1'b1; mem_reg_wen = 1'b1; mem_load = 1'b1;
        mem_load_type = 3'd4; mem_reg_waddr = 5'd6;
        tick();
        mem_valid = 1'b0; mem_load = 1'b0;
        #1;
        check("flush_pre_stall", {31'd0, stall_req}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        ram_rvalid = 1'b1; ram_rdata = 32'h7777_7777;
        #1;
        check("flush_rv_stall", {31'd0, stall_req}, 32'd0);
        check("flush_rv_wen", {31'd0, write_en}, 32'd0);
        tick();
        ram_rvalid = 1'b0;
        check("flush_wen", {31'd0, write_en}, 32'd0);
        tick();
        check("flush_cnt", retired_cnt, exp_cnt);
        $display("flush cnt=%0d", retired_cnt);

        // Reset while a load is pending.
        mem_valid = 1'b1; mem_load = 1'b1;
        tick();
        mem_valid = 1'b0; mem_load = 1'b0;
        #1;
        check("rst2_pre_stall", {31'd0, stall_req}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst2_stall", {31'd0, stall_req}, 32'd0);
        check("rst2_cnt", retired_cnt, 32'd0);
        $display("reset2 cnt=%0d", retired_cnt);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
